// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-SRAM arbiter slice.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DFLT = 7;
  localparam int unsigned DATA_W_DFLT = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_slot_t;

  // Widths follow the package defaults; the top is built with matching parameters.
  typedef struct packed {
    logic                   cen_n;
    logic                   wen_n;
    logic                   oen_n;
    logic [ADDR_W_DFLT-1:0] a;
    logic [DATA_W_DFLT-1:0] d;
  } sram_op_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshakes plus SRAM pins for the data-SRAM arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = dmem_arb_pkg::ADDR_W_DFLT,
  parameter int unsigned DATA_W = dmem_arb_pkg::DATA_W_DFLT
);

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              sram_cen_n, sram_wen_n, sram_oen_n;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_d;
  logic [DATA_W-1:0] sram_q;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_q,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output sram_cen_n, sram_wen_n, sram_oen_n, sram_a, sram_d
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_q,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  sram_cen_n, sram_wen_n, sram_oen_n, sram_a, sram_d
  );

endinterface

// File: rtl/dmem_arb_rdpipe.sv
// Tagged read-return pipeline: routes sram_q to the port that issued each read.
module dmem_arb_rdpipe
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  rd_slot_t          push,
  input  logic [DATA_W-1:0] sram_q,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  rd_slot_t [RD_LAT:0] sr_q;
  rd_slot_t            tail;
  logic                hit0, hit1;

  // The tail slot lines up with the cycle in which sram_q is valid.
  assign tail = sr_q[RD_LAT];
  assign hit0 = tail.valid && (tail.port == PORT_CPU);
  assign hit1 = tail.valid && (tail.port == PORT_DMA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q    <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      sr_q    <= {sr_q[RD_LAT-1:0], push};
      rvalid0 <= hit0;
      rvalid1 <= hit1;
      if (hit0) rdata0 <= sram_q;
      if (hit1) rdata1 <= sram_q;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port fixed-priority arbiter for the data SRAM with a port-1 starvation guard.
// DMEM_ARBITER_STATS_EN adds grant/starvation statistic counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DFLT,
  parameter int unsigned DATA_W     = DATA_W_DFLT,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  dmem_arbiter_if.slave   bus
`ifdef DMEM_ARBITER_STATS_EN
  ,
  output logic [15:0]     stat_gnt0,
  output logic [15:0]     stat_gnt1,
  output logic [15:0]     stat_starve
`endif
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0]        starve_q, starve_d;
  logic              gnt0, gnt1, forced;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  sram_op_t          op_q, op_d;
  rd_slot_t          slot;

  always_comb begin
    forced = bus.req1 && bus.req0 && (starve_q == StarveMax);
    gnt1   = bus.req1 && (!bus.req0 || (starve_q == StarveMax));
    gnt0   = bus.req0 && !gnt1;
  end

  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;

  always_comb begin
    sel_we    = gnt1 ? bus.we1    : bus.we0;
    sel_addr  = gnt1 ? bus.addr1  : bus.addr0;
    sel_wdata = gnt1 ? bus.wdata1 : bus.wdata0;

    // Idle cycles deassert the controls but keep address/data stable.
    op_d       = op_q;
    op_d.cen_n = 1'b1;
    op_d.wen_n = 1'b1;
    op_d.oen_n = 1'b1;
    slot       = '0;
    if (gnt0 || gnt1) begin
      op_d.cen_n = 1'b0;
      op_d.a     = sel_addr;
      if (sel_we) begin
        op_d.wen_n = 1'b0;
        op_d.d     = sel_wdata;
      end else begin
        op_d.oen_n = 1'b0;
        slot.valid = 1'b1;
        slot.port  = gnt1 ? PORT_DMA : PORT_CPU;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.req1 || gnt1) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= '0;
      op_q.cen_n <= 1'b1;
      op_q.wen_n <= 1'b1;
      op_q.oen_n <= 1'b1;
      op_q.a     <= '0;
      op_q.d     <= '0;
    end else begin
      starve_q <= starve_d;
      op_q     <= op_d;
    end
  end

  assign bus.sram_cen_n = op_q.cen_n;
  assign bus.sram_wen_n = op_q.wen_n;
  assign bus.sram_oen_n = op_q.oen_n;
  assign bus.sram_a     = op_q.a;
  assign bus.sram_d     = op_q.d;

  dmem_arb_rdpipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk     (clk),
    .rst     (rst),
    .push    (slot),
    .sram_q  (bus.sram_q),
    .rvalid0 (bus.rvalid0),
    .rvalid1 (bus.rvalid1),
    .rdata0  (bus.rdata0),
    .rdata1  (bus.rdata1)
  );

`ifdef DMEM_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_gnt0   <= '0;
      stat_gnt1   <= '0;
      stat_starve <= '0;
    end else begin
      if (gnt0 && (stat_gnt0 != 16'hFFFF))     stat_gnt0   <= stat_gnt0 + 16'd1;
      if (gnt1 && (stat_gnt1 != 16'hFFFF))     stat_gnt1   <= stat_gnt1 + 16'd1;
      if (forced && (stat_starve != 16'hFFFF)) stat_starve <= stat_starve + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 1-cycle SRAM.
// Build with DMEM_ARBITER_STATS_EN to also check the statistic counters.
module tb_dmem_arbiter;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [DW-1:0] mem [128];

`ifdef DMEM_ARBITER_STATS_EN
  logic [15:0] stat_gnt0, stat_gnt1, stat_starve;
`endif

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .RD_LAT     (1),
    .STARVE_MAX (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef DMEM_ARBITER_STATS_EN
    ,
    .stat_gnt0   (stat_gnt0),
    .stat_gnt1   (stat_gnt1),
    .stat_starve (stat_starve)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM, one cycle from issuing edge to Q.
  always @(posedge clk) begin
    if (!bus.sram_cen_n) begin
      if (!bus.sram_wen_n) mem[bus.sram_a] <= bus.sram_d;
      else if (!bus.sram_oen_n) bus.sram_q <= mem[bus.sram_a];
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every read strobe is matched against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.rvalid0) begin
        if (q0.size() == 0) check("rvalid0 unexpected", 1, 0);
        else begin
          e = q0.pop_front();
          check("rdata0", bus.rdata0, e.data);
          check("rvalid0 cycle", cyc, e.cyc);
        end
      end
      if (bus.rvalid1) begin
        if (q1.size() == 0) check("rvalid1 unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          check("rdata1", bus.rdata1, e.data);
          check("rvalid1 cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic issue(input bit port, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    if (port) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
    @(negedge clk);
    check("gnt0", bus.gnt0, port ? 1'b0 : 1'b1);
    check("gnt1", bus.gnt1, port ? 1'b1 : 1'b0);
    if (!we) begin
      if (port) q1.push_back('{exp_rd, cyc + 3});
      else      q0.push_back('{exp_rd, cyc + 3});
    end
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic check_pins(input string name, input logic cen, input logic wen, input logic oen,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    check({name, " cen_n"}, bus.sram_cen_n, cen);
    check({name, " wen_n"}, bus.sram_wen_n, wen);
    check({name, " oen_n"}, bus.sram_oen_n, oen);
    check({name, " a"}, bus.sram_a, a);
    check({name, " d"}, bus.sram_d, d);
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
    check("q0 drained", q0.size(), 0);
    check("q1 drained", q1.size(), 0);
  endtask

  // Both ports hold read requests; port 1 should win every fifth cycle.
  task automatic contend(input int n);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 7'd1;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 7'd2;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("contend gnt0", bus.gnt0, (i % 5 == 4) ? 1'b0 : 1'b1);
      check("contend gnt1", bus.gnt1, (i % 5 == 4) ? 1'b1 : 1'b0);
      if (i % 5 == 4) q1.push_back('{32'h22222222, cyc + 3});
      else            q0.push_back('{32'h11111111, cyc + 3});
      @(posedge clk);
      #1;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_pins("reset", 1'b1, 1'b1, 1'b1, '0, '0);
    check("reset gnt0", bus.gnt0, 1'b0);
    check("reset rvalid0", bus.rvalid0, 1'b0);
    check("reset rdata1", bus.rdata1, '0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Preload; address 5 is written last so its data stays on sram_d.
    issue(0, 1, 7'd0, 32'hA5A5A5A5, '0);
    issue(1, 1, 7'd1, 32'h11111111, '0);
    issue(1, 1, 7'd2, 32'h22222222, '0);
    issue(1, 1, 7'd3, 32'h33333333, '0);
    issue(1, 1, 7'd4, 32'h44444444, '0);
    issue(1, 1, 7'd5, 32'hDEADBEEF, '0);

    issue(0, 0, 7'd5, '0, 32'hDEADBEEF);
    @(negedge clk);
    check_pins("read5", 1'b0, 1'b1, 1'b0, 7'd5, 32'hDEADBEEF);
    @(negedge clk);
    check_pins("idle", 1'b1, 1'b1, 1'b1, 7'd5, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    drain();

    // Write at the top address, read it back next cycle, then check no alias at 0.
    issue(1, 1, 7'h7F, 32'h12345678, '0);
    fork
      issue(0, 0, 7'h7F, '0, 32'h12345678);
      begin
        @(negedge clk);
        check_pins("write7f", 1'b0, 1'b0, 1'b1, 7'h7F, 32'h12345678);
      end
    join
    issue(1, 0, 7'd0, '0, 32'hA5A5A5A5);
    drain();

    issue(0, 0, 7'd1, '0, 32'h11111111);
    issue(1, 0, 7'd2, '0, 32'h22222222);
    issue(0, 0, 7'd3, '0, 32'h33333333);
    issue(1, 0, 7'd4, '0, 32'h44444444);
    drain();

    contend(10);
    drain();

    // Two reads in flight when reset hits must never return.
    issue(0, 0, 7'd1, '0, 32'h11111111);
    issue(1, 0, 7'd2, '0, 32'h22222222);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    @(negedge clk);
    check_pins("midreset", 1'b1, 1'b1, 1'b1, '0, '0);
    check("midreset rdata0", bus.rdata0, '0);
    check("midreset rvalid1", bus.rvalid1, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    drain();

`ifdef DMEM_ARBITER_STATS_EN
    check("stat_gnt0 cleared", stat_gnt0, '0);
    contend(50);
    drain();
    check("stat_gnt0", stat_gnt0, 16'd40);
    check("stat_gnt1", stat_gnt1, 16'd10);
    check("stat_starve", stat_starve, 16'd10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data SRAM (active-low CEN/WEN/OEN, 7-bit word address, 32-bit data) between two requesters: port 0 = CPU load/store path, port 1 = loader/debug DMA.
- Fixed priority to port 0, with a starvation guard that forces a port-1 grant after STARVE_MAX denied cycles.
- Fully pipelined: registered SRAM pins, one access per cycle, in-order read return tagged per port.

Parameters:
- ADDR_W, 7: SRAM word-address width.
- DATA_W, 32: data width.
- RD_LAT, 1: SRAM cycles from the issuing edge to Q valid (1..3).
- STARVE_MAX, 4: consecutive denied port-1 cycles before port 1 is forced to win (1..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  access request; held until granted.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  combinational accept pulse; request fields are captured this cycle.
- rvalid0 / rvalid1  out  1  one-cycle read-data-valid strobe.
- rdata0 / rdata1  out  DATA_W  read data; holds its last value when rvalid is low.
- sram_cen_n / sram_wen_n / sram_oen_n  out  1  SRAM controls, active-low, registered.
- sram_a  out  ADDR_W  registered address.
- sram_d  out  DATA_W  registered write data.
- sram_q  in  DATA_W  SRAM read data.

Behaviour:
- Reset (async assert, sync release):
  - sram_cen_n = sram_wen_n = sram_oen_n = 1; sram_a = 0; sram_d = 0.
  - gnt = 0, rvalid = 0, rdata = 0; starve_cnt = 0; read pipeline emptied.
  - Reads in flight when reset asserts are dropped and never produce rvalid.
- Arbitration (combinational, every cycle):
  - Port 1 wins if req1 && (!req0 || starve_cnt == STARVE_MAX); otherwise port 0 wins if req0.
  - At most one gnt per cycle; gnt is never asserted without the matching req.
- Starvation counter (4 bits):
  - Increments each cycle req1 && !gnt1, saturating at STARVE_MAX.
  - Clears on gnt1 or when req1 is low.
- Issue: a grant in cycle t registers the SRAM pins for cycle t+1:
  - cen_n = 0.
  - Write: wen_n = 0, oen_n = 1, sram_d = wdata.
  - Read: wen_n = 1, oen_n = 0; sram_d holds its previous value.
  - sram_a = addr.
  - No grant: cen_n = wen_n = oen_n = 1; sram_a and sram_d hold.
- Read return:
  - Each read pushes its port ID into a shift pipeline of depth RD_LAT+1; writes push an empty slot.
  - sram_q is sampled at the end of cycle t+1+RD_LAT; rvalidX/rdataX are presented in cycle t+2+RD_LAT. With RD_LAT=1, grant in cycle 0 gives rvalid in cycle 3.
  - Back-to-back reads return back-to-back, in grant order.
- Writes produce no response; gnt is the completion.
- Ordering: a write then a read to the same address, on either port, returns the new data (the SRAM executes in issue order).
- Simultaneous req0 and req1 with starve_cnt < STARVE_MAX: gnt0 only; the counter increments.
- A requester deasserting req without a grant is legal; nothing is issued.

Optional Feature:
- Macro DMEM_ARBITER_STATS_EN.
- Defined: adds outputs stat_gnt0, stat_gnt1 (16-bit, saturating at 16'hFFFF) and stat_starve (16-bit, counts forced port-1 wins). All are cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - ADDR_W and DATA_W defaults.
  - Port-ID constants: PORT_CPU = 1'b0, PORT_DMA = 1'b1.
  - Typedef for the read-pipeline slot: valid and port ID.
  - Typedef for the SRAM-op struct: cen_n, wen_n, oen_n, a, d.
- One sub-module, dmem_arb_rdpipe: the RD_LAT+1 tagged shift register plus the rdata/rvalid output registers.

Test Plan:
- Reset: assert rst mid-stream with 2 reads in flight -> no rvalid afterwards; all SRAM controls = 1; rdata0 = rdata1 = 0.
- Single read: SRAM word 5 = 32'hDEADBEEF; req0 read addr 5 in cycle 0 -> gnt0 in cycle 0; sram_a = 5 with cen_n = oen_n = 0 in cycle 1; rvalid0 with rdata0 = 32'hDEADBEEF in cycle 3.
- Write then read: port 1 writes 32'h12345678 to addr 7F; next cycle port 0 reads addr 7F -> rdata0 = 32'h12345678; the address wraps correctly at 7F.
- Contention and starvation: req0 and req1 held continuously, STARVE_MAX = 4 -> gnt0 for 4 cycles, gnt1 in cycle 5, then the pattern repeats (4:1).
- Back-to-back mixed reads: alternating port 0/port 1 reads of addrs 1, 2, 3, 4 in consecutive cycles -> rvalid0/rvalid1 alternate in cycles 3-6 with the correct data, in grant order.
- STATS_EN build: the contention pattern above for 50 cycles -> stat_gnt0 = 40, stat_gnt1 = 10, stat_starve = 10.
